// File: rtl/addsub_pkg.sv
// Shared types and default sizing for the slice-serial adder/subtractor.
package addsub_pkg;
   localparam int DEF_WIDTH = 16;
   localparam int DEF_SLICE = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/addsub_slice.sv
// SLICE-bit ripple adder; also reports the carry into its MSB so the caller
// can form signed overflow on the top slice.
module addsub_slice #(
   parameter int SLICE = 4
) (
   input  logic [SLICE-1:0] x,
   input  logic [SLICE-1:0] y,
   input  logic             ci,
   output logic [SLICE-1:0] s,
   output logic             co,
   output logic             cm
);
   logic c;

   always_comb begin
      c  = ci;
      s  = '0;
      cm = 1'b0;
      for (int i = 0; i < SLICE; i++) begin
         if (i == SLICE - 1) cm = c;
         s[i] = x[i] ^ y[i] ^ c;
         c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      co = c;
   end
endmodule

// File: rtl/addsub_seq.sv
// Slice-serial add/subtract with accumulator, one SLICE per cycle, LSB first.
// Optional saturation on signed overflow when SATURATE_EN is defined.
module addsub_seq
   import addsub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SLICE = DEF_SLICE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   input  logic             acc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ov,
   output logic             zero,
   output state_t           state_dbg
);
   localparam int NSLICE = WIDTH / SLICE;
   localparam int IW     = $clog2(NSLICE + 1);
   localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

   // Handshakes: a transfer happens on a rising edge where valid and ready
   // are both 1; valid holds its payload stable until that edge.

   state_t           state;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             carry;
   logic [WIDTH-1:0] acc_r;
   logic [WIDTH-1:0] a_next;
   logic [WIDTH-1:0] fin;
   logic [SLICE-1:0] sl_s;
   logic             sl_co;
   logic             sl_cm;

   addsub_slice #(.SLICE(SLICE)) u_slice (
      .x  (op_a[SLICE-1:0]),
      .y  (op_b[SLICE-1:0]),
      .ci (carry),
      .s  (sl_s),
      .co (sl_co),
      .cm (sl_cm)
   );

   // op_a doubles as the result register: each slice sum enters at the top,
   // so after NSLICE shifts it holds the full result.
   if (WIDTH > SLICE) begin : g_multi
      assign a_next = {sl_s, op_a[WIDTH-1:SLICE]};
   end else begin : g_single
      assign a_next = sl_s;
   end

   always_comb begin
      fin = a_next;
`ifdef SATURATE_EN
      // On the last slice op_a[SLICE-1] is still the original operand-A MSB.
      if (sl_co ^ sl_cm)
         fin = op_a[SLICE-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
   end

   assign in_ready  = (state == IDLE);
   assign state_dbg = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         op_a      <= '0;
         op_b      <= '0;
         carry     <= 1'b0;
         acc_r     <= '0;
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ov        <= 1'b0;
         zero      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_a  <= acc ? acc_r : a;
                  op_b  <= b ^ {WIDTH{sub}};
                  carry <= cin | sub;
                  idx   <= '0;
                  state <= BUSY;
               end
            end
            BUSY: begin
               op_a  <= a_next;
               op_b  <= op_b >> SLICE;
               carry <= sl_co;
               idx   <= idx + 1'b1;
               if (idx == LAST) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  sum       <= fin;
                  cout      <= sl_co;
                  ov        <= sl_co ^ sl_cm;
                  zero      <= (fin == '0);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  acc_r     <= sum;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_addsub_seq.sv
// Directed bench for addsub_seq with an expected-result queue.
module tb_addsub_seq;
   import addsub_pkg::*;

   localparam int W  = 16;
   localparam int NS = 4;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         acc;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ov;
   logic         zero;
   state_t       state_dbg;

   int checks   = 0;
   int failures = 0;
   logic [W+2:0] exp_q[$];
   logic [W+2:0] last_exp;
   logic [W-1:0] model_acc;

   addsub_seq #(.WIDTH(W), .SLICE(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .acc       (acc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ov        (ov),
      .zero      (zero),
      .state_dbg (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: wide arithmetic with sign-rule overflow.
   function automatic logic [W+2:0] model(input logic [W-1:0] ae, input logic [W-1:0] bi,
                                          input logic ci, input logic sb);
      logic [W-1:0] bb;
      logic [W:0]   full;
      logic [W-1:0] r;
      logic         ovf;
      bb   = sb ? ~bi : bi;
      full = {1'b0, ae} + {1'b0, bb} + {{W{1'b0}}, (ci | sb)};
      r    = full[W-1:0];
      ovf  = (ae[W-1] == bb[W-1]) && (r[W-1] != ae[W-1]);
`ifdef SATURATE_EN
      if (ovf) r = ae[W-1] ? 16'h8000 : 16'h7FFF;
`endif
      return {r, full[W], ovf, (r == '0)};
   endfunction

   // driver: present one request and let it be accepted
   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                       input logic tsub, input logic tacc);
      @(negedge clk);
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      exp_q.push_back(model(tacc ? model_acc : ta, tb, tcin, tsub));
      a = ta; b = tb; cin = tcin; sub = tsub; acc = tacc; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // wait for out_valid (bounded), check latency and result against queue head
   task automatic wait_check();
      int lat;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", 32'(lat), 32'(NS));
      if (exp_q.size() == 0) begin
         chk("queue_empty", 32'd0, 32'd1);
      end else begin
         last_exp = exp_q.pop_front();
         chk("sum",  32'(sum),  32'(last_exp[W+2:3]));
         chk("cout", 32'(cout), 32'(last_exp[2]));
         chk("ov",   32'(ov),   32'(last_exp[1]));
         chk("zero", 32'(zero), 32'(last_exp[0]));
      end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      model_acc = last_exp[W+2:3];
      chk("out_valid_drop", 32'(out_valid), 32'd0);
      chk("in_ready_back",  32'(in_ready),  32'd1);
   endtask

   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                        input logic tsub, input logic tacc);
      send(ta, tb, tcin, tsub, tacc);
      wait_check();
      release_out();
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0; acc = 1'b0;
      model_acc = '0; last_exp = '0;
      #22;
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum",       32'(sum),       32'd0);
      chk("rst_flags",     32'({cout, ov, zero}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      do_op(16'h0005, 16'h0003, 1'b0, 1'b0, 1'b0);
      do_op(16'h0003, 16'h0003, 1'b0, 1'b1, 1'b0);

      // out_ready high long before the result exists
      out_ready = 1'b1;
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
      wait_check();
      release_out();

      // stall in DONE with a competing request on the input
      send(16'h1234, 16'h0101, 1'b1, 1'b0, 1'b0);
      wait_check();
      a = 16'hFFFF; b = 16'hFFFF; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_sum",   32'(sum),       32'(last_exp[W+2:3]));
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_ready", 32'(in_ready),  32'd0);
         chk("hold_state", 32'(state_dbg), 32'(DONE));
      end
      in_valid = 1'b0;
      release_out();
      @(negedge clk);
      chk("no_second_accept", 32'(in_ready), 32'd1);

      // accumulator chain
      do_op(16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) do_op(16'hABCD, 16'h0001, 1'b0, 1'b0, 1'b1);
      chk("acc_final", 32'(sum), 32'h0013);

      do_op(16'h0000, 16'h0001, 1'b1, 1'b1, 1'b0);
      do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
      do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 6; i++)
         do_op(W'($urandom_range(0, 16'hFFFF)), W'($urandom_range(0, 16'hFFFF)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      // reset in the second BUSY cycle
      send(16'h0100, 16'h0200, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_sum",       32'(sum),       32'd0);
      chk("mid_rst_flags",     32'({cout, ov, zero}), 32'd0);
      chk("mid_rst_state",     32'(state_dbg), 32'(IDLE));
      void'(exp_q.pop_back());
      model_acc = '0;
      @(negedge clk);
      rst_n = 1'b1;
      do_op(16'h1111, 16'h0005, 1'b0, 1'b0, 1'b1);
      do_op(16'h0300, 16'h0200, 1'b0, 1'b0, 1'b0);

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/addsub_seq.md
ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand/result width in bits, at least 4 and a multiple of SLICE.
REQ-002 The block SHALL have parameter SLICE, default 4: bits processed per cycle; NSLICE = WIDTH/SLICE.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operation request is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: operands, two's complement.
REQ-008 The block SHALL have port cin, input, 1 bit: carry-in for add; ORed in (forced 1) for subtract.
REQ-009 The block SHALL have port sub, input, 1 bit: 1 = a - b (b inverted, carry forced 1); 0 = a + b + cin.
REQ-010 The block SHALL have port acc, input, 1 bit: 1 = use the internal accumulator in place of a.
REQ-011 The block SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit): result handshake.
REQ-012 The block SHALL have port sum, output, WIDTH bits: the result.
REQ-013 The block SHALL have ports cout, ov and zero, output, 1 bit each: unsigned carry-out, signed overflow, and result == 0.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; a request is accepted when in_valid and in_ready are both 1.
REQ-016 On accept, the block SHALL latch the operands (a, or the accumulator when acc=1, and b xor {WIDTH{sub}}) plus carry cin|sub, clear the slice index, and go to BUSY.
REQ-017 In BUSY, the block SHALL add one SLICE per cycle, LSB slice first, and register the carry between slices.
REQ-018 The FSM SHALL move to DONE after NSLICE BUSY cycles, so out_valid rises exactly NSLICE cycles after the accept edge (4 for the defaults).
REQ-019 In DONE, out_valid SHALL be 1 and sum/cout/ov/zero SHALL stay stable until out_ready=1, then the FSM returns to IDLE the next cycle.
REQ-020 ov SHALL equal the carry into the MSB xor the carry out of the MSB; cout SHALL be the carry out of the MSB, raw, not inverted, for subtract.
REQ-021 The accumulator SHALL load sum at the DONE-to-IDLE transfer, whatever the value of acc.
REQ-022 in_valid during BUSY or DONE SHALL be ignored; the request is not queued.
REQ-023 out_ready held at 1 before DONE SHALL have no effect.
REQ-024 The result SHALL wrap modulo 2^WIDTH unless saturation is enabled.

Reset
REQ-025 rst_n=0 SHALL force, at any time including mid-BUSY, the FSM to IDLE and in_ready=1 (in_ready is combinational from state), with out_valid, sum, cout, ov, zero, the accumulator and the slice index all 0.
REQ-026 Any in-flight operation SHALL be discarded on reset.

Configuration
REQ-027 When SATURATE_EN is defined and ov=1, sum SHALL be clamped: {0,{WIDTH-1{1}}} if the true result is positive (operand-A MSB 0), otherwise {1,{WIDTH-1{0}}}; ov still reports 1; the accumulator loads the clamped value.
REQ-028 When SATURATE_EN is undefined, sum SHALL wrap, with no clamp logic present.

Structure
REQ-029 Package addsub_pkg SHALL hold the state enum (IDLE/BUSY/DONE) and the default WIDTH/SLICE constants.
REQ-030 Sub-module addsub_slice SHALL be a SLICE-bit ripple adder (x, y, ci -> s, co, and carry into its MSB for ov), instantiated once and reused each BUSY cycle.

Verification
REQ-031 Reset, then a=0x0005, b=0x0003, sub=0, cin=0 -> out_valid after 4 cycles, sum=0x0008, cout=0, ov=0, zero=0.
REQ-032 a=0x0003, b=0x0003, sub=1 -> sum=0x0000, zero=1, cout=1, ov=0.
REQ-033 a=0x7FFF, b=0x0001, sub=0 -> ov=1; sum=0x8000 without SATURATE_EN, sum=0x7FFF with it.
REQ-034 Hold out_ready=0 for 5 cycles in DONE with in_valid=1 throughout -> result stable, in_ready=0, no second accept; then out_ready=1 -> IDLE next cycle.
REQ-035 Accumulate: a=0x0010 (acc=0), then b=0x0001 with acc=1 three times -> sums 0x0011, 0x0012, 0x0013.
REQ-036 rst_n pulsed low in the 2nd BUSY cycle -> all outputs 0 and in_ready=1 immediately; the next request computes correctly.
